// File: rtl/wb_mem_pkg.sv
// Shared definitions for the Wishbone memory responder.
//   state_e    : responder FSM states (IDLE, WAIT, ACK)
//   WORD_BYTES : bytes per memory word (one byte-write enable per byte)
//   CNT_W      : width of the first-access latency counter
package wb_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = 8;

endpackage

// File: rtl/wb_spram.sv
// Single-port synchronous RAM, 2^ADDR_BITS x 32, with per-byte write enables
// and a registered read port (data appears the cycle after re_i).
//   clk     : clock, rising edge
//   re_i    : read enable; rdata_o updates on the following edge
//   we_i    : byte write enables, bit b writes wdata_i[8b+7:8b]
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : registered read data
// Contents are not reset.
module wb_spram
    import wb_mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                  clk,
    input  logic                  re_i,
    input  logic [WORD_BYTES-1:0] we_i,
    input  logic [ADDR_BITS-1:0]  addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_BITS;

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    // Byte-lane writes and the registered read port.
    always_ff @(posedge clk) begin
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (we_i[b]) begin
                mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone classic-cycle responder backing a word-addressed memory window.
// Non-sequential accesses are acknowledged DELAY cycles after the request is
// first seen; reads that continue a read stream (next word index, stb held)
// are acknowledged in the following cycle.
//   wb_clk_i  : clock          wb_rst_i  : synchronous active-high reset
//   wbs_stb_i : strobe         wbs_cyc_i : bus cycle valid
//   wbs_we_i  : 1 = write      wbs_sel_i : write byte enables
//   wbs_dat_i : write data     wbs_adr_i : byte address ([1:0] ignored)
//   wbs_ack_o : one-cycle ack  wbs_dat_o : read data while acked, else 0
module wb_mem_responder
    import wb_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3800_0000,
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned DELAY     = 10
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o
);

    // WAIT runs from DELAY-2 down to 0, so the ack lands in cycle DELAY.
    localparam logic [CNT_W-1:0] CNT_LOAD = (DELAY > 1) ? CNT_W'(DELAY - 2) : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stream_valid_q, stream_valid_d;
    logic [ADDR_BITS-1:0]   last_addr_q, last_addr_d;
    logic                   last_was_read_q, last_was_read_d;
    logic                   ack_q, ack_d;
    logic                   rd_ack_q, rd_ack_d;

    logic                   hit_s;
    logic                   req_s;
    logic                   seq_s;
    logic [ADDR_BITS-1:0]   idx_s;
    logic [ADDR_BITS-1:0]   next_idx_s;
    logic                   ram_re_s;
    logic [WORD_BYTES-1:0]  ram_we_s;
    logic [31:0]            ram_rdata_s;
    logic                   unused_s;

    assign hit_s      = (wbs_adr_i[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
    assign idx_s      = wbs_adr_i[ADDR_BITS+1:2];
    assign req_s      = wbs_stb_i & wbs_cyc_i & hit_s;
    // Word index wraps at the window end, so the last word streams into word 0.
    assign next_idx_s = last_addr_q + {{(ADDR_BITS-1){1'b0}}, 1'b1};
    assign seq_s      = req_s & ~wbs_we_i & stream_valid_q & last_was_read_q &
                        (idx_s == next_idx_s);
    assign unused_s   = ^wbs_adr_i[1:0];

    // Next-state, RAM control and stream tracking.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        stream_valid_d  = stream_valid_q;
        last_addr_d     = last_addr_q;
        last_was_read_d = last_was_read_q;
        ack_d           = 1'b0;
        rd_ack_d        = 1'b0;
        ram_re_s        = 1'b0;
        ram_we_s        = {WORD_BYTES{1'b0}};

        case (state_q)
            IDLE: begin
                if (req_s) begin
                    if (seq_s || (DELAY == 32'd1)) begin
                        ram_re_s = ~wbs_we_i;
                        ack_d    = 1'b1;
                        rd_ack_d = ~wbs_we_i;
                        state_d  = ACK;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (!(wbs_stb_i && wbs_cyc_i)) begin
                    // Master gave up: drop the access silently.
                    stream_valid_d = 1'b0;
                    state_d        = IDLE;
                end else if (cnt_q == {CNT_W{1'b0}}) begin
                    ram_re_s = ~wbs_we_i;
                    ack_d    = 1'b1;
                    rd_ack_d = ~wbs_we_i;
                    state_d  = ACK;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ACK: begin
                // Write commits on the edge closing the ack cycle unless reset hits it.
                if (wbs_we_i && !wb_rst_i) begin
                    ram_we_s = wbs_sel_i;
                end else begin
                    ram_we_s = {WORD_BYTES{1'b0}};
                end
                last_addr_d     = idx_s;
                last_was_read_d = ~wbs_we_i;
                stream_valid_d  = ~wbs_we_i;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Any cycle with cyc low ends a stream regardless of state.
        stream_valid_d = stream_valid_d & wbs_cyc_i;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q         <= IDLE;
            cnt_q           <= {CNT_W{1'b0}};
            stream_valid_q  <= 1'b0;
            last_addr_q     <= {ADDR_BITS{1'b0}};
            last_was_read_q <= 1'b0;
            ack_q           <= 1'b0;
            rd_ack_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            stream_valid_q  <= stream_valid_d;
            last_addr_q     <= last_addr_d;
            last_was_read_q <= last_was_read_d;
            ack_q           <= ack_d;
            rd_ack_q        <= rd_ack_d;
        end
    end

    wb_spram #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk     (wb_clk_i),
        .re_i    (ram_re_s),
        .we_i    (ram_we_s),
        .addr_i  (idx_s),
        .wdata_i (wbs_dat_i),
        .rdata_o (ram_rdata_s)
    );

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rd_ack_q ? ram_rdata_s : 32'h0000_0000;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Scoreboard bench for wb_mem_responder at default parameters
// (window 0x3800_0000, 1024 words, DELAY = 10).
module tb_wb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] dat_i = 32'h0;
    logic [31:0] adr = 32'h0;
    logic        ack;
    logic [31:0] dat_o;

    typedef struct {
        logic [31:0] dat;
        logic        chk;
        int          cyc;
        int          tag;
    } exp_t;

    exp_t sb_q[$];
    int   cyc_cnt   = 0;
    int   checks    = 0;
    int   passes    = 0;
    int   ack_seen  = 0;
    int   tag_cnt   = 0;
    logic chk_idle  = 1'b0;

    wb_mem_responder dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_dat_i (dat_i),
        .wbs_adr_i (adr),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [31:0] pat(input logic [9:0] i);
        return 32'hC3A5_0000 ^ {6'd0, i, 6'd0, i};
    endfunction

    // Monitor: every ack must match the oldest expectation (cycle and data).
    always @(negedge clk) begin
        exp_t e;
        if (ack) begin
            ack_seen++;
            checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL unexpected_ack: ack at cycle %0d data %h, required no ack", cyc_cnt, dat_o);
            end else begin
                e = sb_q.pop_front();
                if (cyc_cnt == e.cyc && (!e.chk || dat_o === e.dat)) begin
                    passes++;
                end else begin
                    $display("FAIL ack_%0d: cycle %0d data %h, required cycle %0d data %h",
                             e.tag, cyc_cnt, dat_o, e.cyc, e.dat);
                end
            end
        end else if (chk_idle) begin
            checks++;
            if (dat_o === 32'h0) passes++;
            else $display("FAIL idle_dat: dat_o %h at cycle %0d, required 0", dat_o, cyc_cnt);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic expect_ack(input logic [31:0] d, input logic chk, input int at);
        exp_t e;
        e.dat = d; e.chk = chk; e.cyc = at; e.tag = tag_cnt;
        tag_cnt++;
        sb_q.push_back(e);
    endtask

    task automatic start_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output int t0);
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        t0 = cyc_cnt;
    endtask

    task automatic wait_ack(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (got) passes++;
        else $display("FAIL %s_timeout: no ack within 64 cycles, required ack", name);
    endtask

    task automatic xfer(input string name, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] exp_d, input logic keep_cyc);
        int t0;
        start_req(w, a, d, s, t0);
        expect_ack(exp_d, ~w, t0 + 10);
        wait_ack(name);
        @(posedge clk); #1;
        stb = 1'b0; cyc = keep_cyc; we = 1'b0;
    endtask

    // Read n words with stb held, advancing the address after each ack.
    task automatic stream(input logic [31:0] adr0, input int n);
        int t0;
        logic [31:0] a;
        a = adr0;
        start_req(1'b0, a, 32'h0, 4'h0, t0);
        for (int i = 0; i < n; i++) begin
            expect_ack(pat(a[11:2]), 1'b1, t0 + 10 + 2 * i);
            wait_ack("stream");
            @(posedge clk); #1;
            a   = {a[31:12], a[11:2] + 10'd1, 2'b00};
            adr = a;
        end
        stb = 1'b0; cyc = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int t0;
        int base;
        logic [9:0] ix;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ack", {31'b0, ack}, 32'h0);
        check("rst_dat", dat_o, 32'h0);

        // Basic write / read-back.
        xfer("wr_10", 1'b1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
        xfer("rd_10", 1'b0, 32'h3800_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

        // Byte lanes.
        xfer("wr_20", 1'b1, 32'h3800_0020, 32'hAABB_CCDD, 4'hF, 32'h0, 1'b0);
        xfer("wr_20p", 1'b1, 32'h3800_0020, 32'h1122_3344, 4'b0101, 32'h0, 1'b0);
        xfer("rd_20", 1'b0, 32'h3800_0020, 32'h0, 4'h0, 32'hAA22_CC44, 1'b0);

        // Preload words 0x4B..0x8B, then stream 64 words from 0x130.
        for (int i = 0; i < 65; i++) begin
            ix = 10'h04B + i[9:0];
            xfer("pre", 1'b1, {20'h38000, ix, 2'b00}, pat(ix), 4'hF, 32'h0, 1'b0);
        end
        stream(32'h3800_0130, 64);

        // Wrap from the last word to word 0.
        xfer("pre_3ff", 1'b1, 32'h3800_0FFC, pat(10'h3FF), 4'hF, 32'h0, 1'b0);
        xfer("pre_000", 1'b1, 32'h3800_0000, pat(10'h000), 4'hF, 32'h0, 1'b0);
        stream(32'h3800_0FFC, 2);

        // Abort a write in cycle 5; the following read must take full latency.
        xfer("rd_12c", 1'b0, 32'h3800_012C, 32'h0, 4'h0, pat(10'h04B), 1'b1);
        base = ack_seen;
        start_req(1'b1, 32'h3800_0130, 32'h1234_5678, 4'hF, t0);
        repeat (5) @(posedge clk);
        #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_ack", ack_seen, base);
        xfer("rd_130", 1'b0, 32'h3800_0130, 32'h0, 4'h0, pat(10'h04C), 1'b0);

        // Out-of-window request held for 20 cycles.
        base = ack_seen;
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h3000_0000; chk_idle = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk_idle = 1'b0; stb = 1'b0; cyc = 1'b0;
        check("oow_no_ack", ack_seen, base);

        // Reset during the ack cycle of a write suppresses the write.
        start_req(1'b1, 32'h3800_0010, 32'hCAFE_F00D, 4'hF, t0);
        expect_ack(32'h0, 1'b0, t0 + 10);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
        xfer("rd_rst_ack", 1'b0, 32'h3800_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

        // Reset during WAIT: no ack, responder back in IDLE.
        base = ack_seen;
        start_req(1'b0, 32'h3800_0010, 32'h0, 4'h0, t0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1; stb = 1'b0; cyc = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("rst_wait_no_ack", ack_seen, base);
        xfer("rd_rst_wait", 1'b0, 32'h3800_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        check("sb_empty", sb_q.size(), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
